alu_issue: RTL and testbench
============================

# alu_issue

Issue stage that feeds the ALU: it decodes a fetched MIPS instruction plus its register-file read data into the ALU's operation code, shift amount and two operands. It registers the result into the ID/EX pipeline boundary behind a valid/ready handshake, with a one-entry skid buffer and a synchronous flush. It sits between register-file read and the ALU, and is the producer of every `operation`/`shamt`/operand value the ALU consumes.

## Interface
- No parameters; data width is fixed at 32, register index width at 5.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill of all held and incoming instructions.
- `in_valid`  in  1  upstream presents an instruction.
- `in_ready`  out  1  stage can accept; registered, equals "skid buffer empty".
- `instr`  in  32  MIPS instruction word.
- `rs_data`  in  32  register-file value for `instr[25:21]`.
- `rt_data`  in  32  register-file value for `instr[20:16]`.
- `out_valid`  out  1  decoded instruction available to EX.
- `out_ready`  in  1  EX consumes this cycle.
- `operation`  out  3  0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 slt.
- `shamt`  out  5  shift amount (`instr[10:6]` for sll/srl, else 0).
- `op_a`  out  32  ALU reg1.
- `op_b`  out  32  ALU reg2 (rt_data or extended immediate).
- `dest`  out  5  write-back register index.
- `reg_write`  out  1  write-back enable.
- `mem_read` / `mem_write` / `branch`  out  1 each  lw / sw / beq markers.
- `illegal`  out  1  instruction not in the decoded set.

## Operation
- R-type (opcode 0x00), keyed by funct: 0x20/0x21 → 0; 0x22/0x23 → 1; 0x24 → 2; 0x25 → 3; 0x2A → 6; 0x00 → 4; 0x02 → 5. Operands: `op_a`=rs_data, `op_b`=rt_data, `dest`=rd, `reg_write`=1.
- I-type: addi 0x08 / addiu 0x09 → 0, sign-extended immediate. andi 0x0C → 2, zero-extended. ori 0x0D → 3, zero-extended. slti 0x0A → 6, sign-extended. For all of these `dest`=rt and `reg_write`=1.
- lw 0x23 → 0, sign-extended, `dest`=rt, `reg_write`=1, `mem_read`=1.
- sw 0x2B → 0, sign-extended, `reg_write`=0, `mem_write`=1.
- beq 0x04 → 1, `op_b`=rt_data, `reg_write`=0, `branch`=1.
- `reg_write` is forced to 0 whenever `dest`=0. The all-zero word (sll $0) is therefore a true NOP.
- Any other opcode/funct produces: `illegal`=1, `operation`=0, `op_a`=`op_b`=0, `dest`=0, all enables 0. It still flows through the handshake as a normal entry.
- Storage is two entries: main (drives outputs) and skid.
- Accept condition: `in_valid & in_ready`.
- Main loads when it is empty or `out_ready`=1. It takes skid contents if skid is valid, else the incoming decode.
- An accepted input that cannot enter main (main full, `out_ready`=0) goes to skid.
- `in_ready` = !skid_valid, registered.
- Output payload is held stable while `out_valid & !out_ready`.

## Timing
- Reset, asynchronous: `out_valid`=0, skid empty, `in_ready`=1, all payload outputs 0.
- Latency: an instruction accepted at edge N is visible at `out_valid` after edge N (one cycle).
- Throughput: 1 per cycle while `out_ready`=1.
- Back-pressure:
  - First stalled cycle still accepts one input into skid.
  - `in_ready` drops on the following cycle.
  - On release, skid drains into main before new input; ordering is preserved.
- Simultaneous skid drain and new input: the skid entry moves to main, and the new input (legal since `in_ready` was 1 only if skid was empty) never collides.
- Flush has priority over everything:
  - At the edge where `flush`=1, main and skid are cleared, and any input offered in that cycle is discarded.
  - After that edge: `out_valid`=0, `in_ready`=1.
- Reset asserted mid-stall drops both entries immediately, without waiting for the clock.

## Structure
- Shared package `alu_pkg`:
  - ALU operation encodings (0–6).
  - Opcode and funct constants.
  - The decoded-instruction struct: operation, shamt, op_a, op_b, dest, enables, illegal.
- Combinational sub-module `alu_decode` maps `instr`/`rs_data`/`rt_data` to the struct.
- `alu_issue` holds only the handshake, skid and flush logic.

## Test plan
- Reset, then `instr`=0x012A4020 (add $8,$9,$10), rs=5, rt=7 → next cycle `out_valid`=1, operation 0, op_a 5, op_b 7, dest 8, reg_write 1.
- `instr`=0x00094080 (sll $8,$9,2), rt=3 → operation 4, shamt 2, op_b 3. `instr`=0x00000000 → operation 4, reg_write 0, illegal 0.
- addi $2,$1,-1 (0x2022FFFF) → op_b 0xFFFFFFFF. andi $2,$1,0xFFFF (0x3022FFFF) → op_b 0x0000FFFF, operation 2.
- Stream A,B,C with `out_ready`=0 from B's arrival:
  - A is held on the outputs.
  - B is accepted into skid.
  - `in_ready`=0 next cycle; C waits.
  - Raise `out_ready` → outputs A, B, C in order, no loss or duplication.
- With A in main and B in skid, pulse `flush` with C offered → `out_valid`=0 and `in_ready`=1 next cycle; A, B, C never appear.
- Opcode 0x3F → `illegal`=1, operation 0, all enables 0, handshake completes normally. Assert `rst_n`=0 mid-stall → `out_valid` falls without a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: operation codes, MIPS
// opcode/funct constants and the decoded-instruction record.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLL = 3'd4,
    ALU_SRL = 3'd5,
    ALU_SLT = 3'd6
  } alu_op_e;

  // Primary opcodes
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef struct packed {
    alu_op_e             operation;
    logic [REG_W-1:0]    shamt;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [REG_W-1:0]    dest;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic                illegal;
  } decoded_t;

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of a MIPS instruction word plus register read data
// into the operation/operand record consumed by the ALU.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output decoded_t    dec
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt_idx;
  logic [4:0] rd_idx;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  // The rs index is resolved by the register file; only its data arrives here.
  logic unused_rs_field;

  assign opcode          = instr[31:26];
  assign funct           = instr[5:0];
  assign rt_idx          = instr[20:16];
  assign rd_idx          = instr[15:11];
  assign imm_sext        = sext16(instr[15:0]);
  assign imm_zext        = {16'h0000, instr[15:0]};
  assign unused_rs_field = ^instr[25:21];

  // Decode opcode/funct into operation, operands, destination and markers
  always_comb begin
    dec = '0;
    case (opcode)
      OPC_RTYPE: begin
        dec.op_a      = rs_data;
        dec.op_b      = rt_data;
        dec.dest      = rd_idx;
        dec.reg_write = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: dec.operation = ALU_ADD;
          FN_SUB, FN_SUBU: dec.operation = ALU_SUB;
          FN_AND:          dec.operation = ALU_AND;
          FN_OR:           dec.operation = ALU_OR;
          FN_SLT:          dec.operation = ALU_SLT;
          FN_SLL: begin
            dec.operation = ALU_SLL;
            dec.shamt     = instr[10:6];
          end
          FN_SRL: begin
            dec.operation = ALU_SRL;
            dec.shamt     = instr[10:6];
          end
          default: begin
            dec         = '0;
            dec.illegal = 1'b1;
          end
        endcase
      end
      OPC_ADDI, OPC_ADDIU, OPC_SLTI, OPC_ANDI, OPC_ORI, OPC_LW: begin
        dec.op_a      = rs_data;
        dec.dest      = rt_idx;
        dec.reg_write = 1'b1;
        dec.op_b      = imm_sext;
        case (opcode)
          OPC_SLTI: dec.operation = ALU_SLT;
          OPC_ANDI: begin
            dec.operation = ALU_AND;
            dec.op_b      = imm_zext;
          end
          OPC_ORI: begin
            dec.operation = ALU_OR;
            dec.op_b      = imm_zext;
          end
          OPC_LW: begin
            dec.operation = ALU_ADD;
            dec.mem_read  = 1'b1;
          end
          default: dec.operation = ALU_ADD;
        endcase
      end
      OPC_SW: begin
        dec.operation = ALU_ADD;
        dec.op_a      = rs_data;
        dec.op_b      = imm_sext;
        dec.mem_write = 1'b1;
      end
      OPC_BEQ: begin
        dec.operation = ALU_SUB;
        dec.op_a      = rs_data;
        dec.op_b      = rt_data;
        dec.branch    = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Writes to $0 are discarded, which makes the all-zero word a true NOP
    if (dec.dest == 5'd0) dec.reg_write = 1'b0;
  end

endmodule

// File: rtl/alu_issue.sv
// ID/EX boundary for the ALU: registers decoded instructions behind a
// valid/ready handshake with a one-entry skid buffer and synchronous flush.
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  operation,
  output logic [4:0]  shamt,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [4:0]  dest,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        illegal
);

  decoded_t in_dec;
  decoded_t main_q, main_d;
  decoded_t skid_q, skid_d;
  logic     main_valid_q, main_valid_d;
  logic     skid_valid_q, skid_valid_d;
  logic     accept;

  alu_decode u_decode (
    .instr   (instr),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .dec     (in_dec)
  );

  // Next-state for main/skid: flush wins, then drain skid, then take input
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    // Input is only offered a slot while the skid is empty
    accept       = in_valid & ~skid_valid_q;
    if (flush) begin
      main_d       = '0;
      main_valid_d = 1'b0;
      skid_d       = '0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_ready) begin
      if (skid_valid_q) begin
        // accept is 0 here, so the older skid entry never collides with input
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_dec;
      skid_valid_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign operation = main_q.operation;
  assign shamt     = main_q.shamt;
  assign op_a      = main_q.op_a;
  assign op_b      = main_q.op_b;
  assign dest      = main_q.dest;
  assign reg_write = main_q.reg_write;
  assign mem_read  = main_q.mem_read;
  assign mem_write = main_q.mem_write;
  assign branch    = main_q.branch;
  assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  operation;
  logic [4:0]  shamt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  dest;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        illegal;

  int check_count = 0;
  int error_count = 0;

  alu_issue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .operation (operation),
    .shamt     (shamt),
    .op_a      (op_a),
    .op_b      (op_b),
    .dest      (dest),
    .reg_write (reg_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .branch    (branch),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [31:0] rs, input logic [31:0] rt);
    in_valid = v;
    instr    = ins;
    rs_data  = rs;
    rt_data  = rt;
  endtask

  // Check the full decoded payload of the entry currently on the outputs
  task automatic chk_entry(input string tag, input logic [2:0] e_op, input logic [4:0] e_sh,
                           input logic [31:0] e_a, input logic [31:0] e_b,
                           input logic [4:0] e_dest, input logic [4:0] e_flags);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".op"},    {29'd0, operation}, {29'd0, e_op});
    chk({tag, ".shamt"}, {27'd0, shamt}, {27'd0, e_sh});
    chk({tag, ".op_a"},  op_a, e_a);
    chk({tag, ".op_b"},  op_b, e_b);
    chk({tag, ".dest"},  {27'd0, dest}, {27'd0, e_dest});
    // flags = {reg_write, mem_read, mem_write, branch, illegal}
    chk({tag, ".flags"}, {27'd0, reg_write, mem_read, mem_write, branch, illegal},
        {27'd0, e_flags});
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    #12;
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst.op_a",      op_a, 32'd0);
    chk("rst.op_b",      op_b, 32'd0);
    chk("rst.dest",      {27'd0, dest}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Decode vectors, one per cycle, out_ready high
    drive(1'b1, 32'h012A4020, 32'd5, 32'd7);            // add $8,$9,$10
    tick(); chk_entry("add",  3'd0, 5'd0, 32'd5, 32'd7, 5'd8, 5'b10000);
    drive(1'b1, 32'h00094080, 32'd0, 32'd3);            // sll $8,$9,2
    tick(); chk_entry("sll",  3'd4, 5'd2, 32'd0, 32'd3, 5'd8, 5'b10000);
    drive(1'b1, 32'h00000000, 32'd0, 32'd0);            // nop
    tick(); chk_entry("nop",  3'd4, 5'd0, 32'd0, 32'd0, 5'd0, 5'b00000);
    drive(1'b1, 32'h2022FFFF, 32'd11, 32'd99);          // addi $2,$1,-1
    tick(); chk_entry("addi", 3'd0, 5'd0, 32'd11, 32'hFFFFFFFF, 5'd2, 5'b10000);
    drive(1'b1, 32'h3022FFFF, 32'd11, 32'd99);          // andi $2,$1,0xFFFF
    tick(); chk_entry("andi", 3'd2, 5'd0, 32'd11, 32'h0000FFFF, 5'd2, 5'b10000);
    drive(1'b1, 32'h8C22FFF8, 32'd100, 32'd99);         // lw $2,-8($1)
    tick(); chk_entry("lw",   3'd0, 5'd0, 32'd100, 32'hFFFFFFF8, 5'd2, 5'b11000);
    drive(1'b1, 32'hAC220004, 32'd100, 32'd99);         // sw $2,4($1)
    tick(); chk_entry("sw",   3'd0, 5'd0, 32'd100, 32'd4, 5'd0, 5'b00100);
    drive(1'b1, 32'h10220003, 32'd6, 32'd9);            // beq $1,$2,3
    tick(); chk_entry("beq",  3'd1, 5'd0, 32'd6, 32'd9, 5'd0, 5'b00010);
    drive(1'b1, 32'hFC000000, 32'd5, 32'd7);            // opcode 0x3F
    tick(); chk_entry("ill",  3'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'b00001);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("idle.out_valid", {31'd0, out_valid}, 32'd0);

    // Back-pressure: A, B, C tagged by rs_data
    drive(1'b1, 32'h012A4020, 32'hA, 32'd1);
    tick();
    chk("bp.A_main", op_a, 32'hA);
    out_ready = 1'b0;
    drive(1'b1, 32'h012A4020, 32'hB, 32'd1);
    tick();
    chk("bp.A_held", op_a, 32'hA);
    chk("bp.in_ready_low", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'h012A4020, 32'hC, 32'd1);
    tick();
    chk("bp.A_still", op_a, 32'hA);
    chk("bp.C_waits", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp.B_out", op_a, 32'hB);
    chk("bp.B_valid", {31'd0, out_valid}, 32'd1);
    chk("bp.in_ready_up", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp.C_out", op_a, 32'hC);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("bp.drained", {31'd0, out_valid}, 32'd0);

    // Flush with A in main, B in skid, C offered
    drive(1'b1, 32'h012A4020, 32'hA, 32'd1);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 32'h012A4020, 32'hB, 32'd1);
    tick();
    chk("fl.skid_full", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    drive(1'b1, 32'h012A4020, 32'hC, 32'd1);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    out_ready = 1'b1;
    chk("fl.out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl.in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl.nothing", {31'd0, out_valid}, 32'd0);
    end

    // Asynchronous reset mid-stall
    drive(1'b1, 32'h012A4020, 32'hA, 32'd1);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 32'h012A4020, 32'hB, 32'd1);
    tick();
    chk("ar.stalled", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.out_valid", {31'd0, out_valid}, 32'd0);
    chk("ar.in_ready", {31'd0, in_ready}, 32'd1);
    chk("ar.op_a", op_a, 32'd0);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    #10 rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
